mem_proto_checker: RTL

MEM_PROTO_CHECKER -- requirements
Module: mem_proto_checker

---
 rtl/mem_proto_checker_pkg.sv | 32 +++
 rtl/mem_shadow.sv | 49 ++++
 rtl/mem_proto_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_proto_checker_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_proto_checker_pkg                                                    |
// | Shared types, event indices and saturating arithmetic for the checker.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_proto_checker_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int EV_TIMEOUT  = 0;
    localparam int EV_UNSTABLE = 1;
    localparam int EV_SPURIOUS = 2;
    localparam int EV_DATA     = 3;
    localparam int NUM_EV      = 4;

    // Adds amt to cur and clamps at lim; a 33-bit sum keeps 32-bit operands safe.
    function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                            input logic [31:0] amt,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, amt};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_shadow.sv
// +--------------------------------------------------------------------------+
// | mem_shadow                                                               |
// | Shadow copy of written data with per-entry written bits.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_shadow
    import mem_proto_checker_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  written_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;

    // Data contents are never reset; the written bits alone say what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else if (we_i) begin
            written_q[waddr_i] <= 1'b1;
        end
    end

    assign rdata_o   = mem_q[raddr_i];
    assign written_o = written_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/mem_proto_checker.sv
// +--------------------------------------------------------------------------+
// | mem_proto_checker                                                        |
// | Passive valid/ready memory-bus monitor with sticky errors and counters.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_proto_checker
    import mem_proto_checker_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8,
    parameter int MAX_WAIT   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  clr_err,
    output logic                  err_timeout,
    output logic                  err_unstable,
    output logic                  err_spurious,
    output logic                  err_data,
    output logic                  err_any,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int          WCNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [31:0] c_CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    state_t                  state_q, state_d;
    logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    req_wr_q, req_wr_d;
    logic [WIDTH-1:0]        req_wdata_q, req_wdata_d;
    logic                    unst_done_q, unst_done_d;
    logic [NUM_EV-1:0]       flags_q, flags_d;
    logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;

    logic                    w_hs;
    logic                    w_req_changed;
    logic [NUM_EV-1:0]       w_ev;
    logic [31:0]             w_ev_num;
    logic [WIDTH-1:0]        w_shadow_data;
    logic                    w_shadow_written;

    assign w_hs = valid & ready;

    mem_shadow #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .we_i       (w_hs & wr_rd),
        .waddr_i    (addr),
        .wdata_i    (wdata),
        .raddr_i    (addr),
        .rdata_o    (w_shadow_data),
        .written_o  (w_shadow_written)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            req_wdata_q <= '0;
            unst_done_q <= 1'b0;
            flags_q     <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_addr_q  <= req_addr_d;
            req_wr_q    <= req_wr_d;
            req_wdata_q <= req_wdata_d;
            unst_done_q <= unst_done_d;
            flags_q     <= flags_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // wdata only matters for a captured write; read requests may let it float.
    assign w_req_changed = (addr != req_addr_q) || (wr_rd != req_wr_q) ||
                           (req_wr_q && (wdata != req_wdata_q));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_addr_d  = req_addr_q;
        req_wr_d    = req_wr_q;
        req_wdata_d = req_wdata_q;
        unst_done_d = unst_done_q;
        w_ev        = '0;

        case (state_q)
            ST_IDLE: begin
                if (valid && !ready) begin
                    state_d     = ST_WAIT;
                    wait_cnt_d  = '0;
                    req_addr_d  = addr;
                    req_wr_d    = wr_rd;
                    req_wdata_d = wdata;
                    unst_done_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // Timeout fires as the counter steps onto MAX_WAIT; it then
                // saturates there, so the event cannot repeat for this request.
                wait_cnt_d = WCNT_W'(sat_add(32'(wait_cnt_q), 32'd1, 32'(MAX_WAIT)));
                if (valid && !ready && (wait_cnt_q == WCNT_W'(MAX_WAIT - 1))) begin
                    w_ev[EV_TIMEOUT] = 1'b1;
                end
                if (!unst_done_q && (!valid || w_req_changed)) begin
                    w_ev[EV_UNSTABLE] = 1'b1;
                    unst_done_d       = 1'b1;
                end
                if (w_hs || !valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        w_ev[EV_SPURIOUS] = ready & ~valid;
        w_ev[EV_DATA]     = w_hs & ~wr_rd & w_shadow_written & (rdata != w_shadow_data);

        if (rst) begin
            w_ev = '0;
        end
    end

    assign w_ev_num = 32'(w_ev[EV_TIMEOUT]) + 32'(w_ev[EV_UNSTABLE]) +
                      32'(w_ev[EV_SPURIOUS]) + 32'(w_ev[EV_DATA]);

    // A fresh event outranks clr_err in the same cycle.
    assign flags_d   = (flags_q & {NUM_EV{~clr_err}}) | w_ev;
    assign wr_cnt_d  = (w_hs &  wr_rd) ? CNT_WIDTH'(sat_add(32'(wr_cnt_q), 32'd1, c_CNT_MAX)) : wr_cnt_q;
    assign rd_cnt_d  = (w_hs & ~wr_rd) ? CNT_WIDTH'(sat_add(32'(rd_cnt_q), 32'd1, c_CNT_MAX)) : rd_cnt_q;
    assign err_cnt_d = CNT_WIDTH'(sat_add(32'(err_cnt_q), w_ev_num, c_CNT_MAX));

    assign err_timeout  = flags_q[EV_TIMEOUT];
    assign err_unstable = flags_q[EV_UNSTABLE];
    assign err_spurious = flags_q[EV_SPURIOUS];
    assign err_data     = flags_q[EV_DATA];
    assign err_any      = |flags_q;
    assign wr_cnt       = wr_cnt_q;
    assign rd_cnt       = rd_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

`default_nettype wire
